// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Multi-cycle instruction-fetch controller. It requests the instruction at the
// current PC from instruction memory, holds the returned word for decode, and
// when decode accepts it pulses the program-counter load enable and picks the
// sequential (pc+4) or branch-target (pc+ImmExt) update.
//
// Ports
//   clk           rising-edge clock
//   Async_reset   asynchronous, active-low reset
//   pc            current PC from the program counter
//   imem_req      instruction memory request (high for the whole REQ phase)
//   imem_addr     request address (pc while requesting, else 0)
//   imem_ack      one-cycle pulse, imem_rdata valid
//   imem_rdata    fetched instruction
//   id_ready      decode accepts the held instruction this cycle
//   branch_taken  redirect decision, only looked at on an accept cycle
//   halt          stop issuing new fetches
//   instr_valid   held instruction valid to decode
//   instr         held instruction
//   instr_pc      address of the held instruction
//   pc_load       program counter load enable
//   pc_src        program counter source select (1 = pc+ImmExt)
//   fetch_fault   sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned MAX_WAIT = 15  // legal range 1..255
) (
  input  logic        clk,
  input  logic        Async_reset,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        pc_load,
  output logic        pc_src,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge Async_reset) begin
    if (!Async_reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Counter never exceeds MAX_WAIT, so the 8-bit increment cannot wrap.
  assign wait_inc = wait_q + 8'd1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    fetch_fault = 1'b0;
    instr       = instr_q;
    instr_pc    = instr_pc_q;

    unique case (state_q)
      IDLE: begin
        if (!halt) state_d = REQ;
      end

      REQ: begin
        // imem_ack only steers registered state here; the request outputs
        // depend on state_q alone, so there is no ack-to-req/load path.
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          wait_d     = '0;
          state_d    = HOLD;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == MAX_WAIT_C) state_d = FAULT;
        end
      end

      HOLD: begin
        instr_valid = 1'b1;
        if (id_ready) begin
          pc_load = 1'b1;
          pc_src  = branch_taken;
          // halt is honoured only here, never in the middle of a request.
          state_d = halt ? IDLE : REQ;
        end
      end

      FAULT: begin
        fetch_fault = 1'b1;
        instr       = '0;
        instr_pc    = '0;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench: a directed vector table for the first fetches after
// reset, hand-written sequences for the multi-cycle corners (long HOLD with
// branch, timeout, ack on the last allowed cycle, halt, async reset), then
// randomized traffic against a transaction-level reference model. The bench
// also plays the program counter, updating it from the model's accept cycles.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        Async_reset = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pc_load;
  logic        pc_src;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .Async_reset  (Async_reset),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_ready     (id_ready),
    .branch_taken (branch_taken),
    .halt         (halt),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_load      (pc_load),
    .pc_src       (pc_src),
    .fetch_fault  (fetch_fault)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        load;
    logic        src;
    logic        fault;
    logic [31:0] instr;
    logic [31:0] ipc;
  } outs_t;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic        hlt;
    outs_t       e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the fetch unit is doing, at transaction level.
  bit          m_fetching;   // a request is outstanding
  bit          m_holding;    // an instruction waits for decode
  bit          m_faulted;    // timed out, dead until reset
  int          m_waited;     // cycles the outstanding request has gone unanswered
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_pc;         // architectural PC the bench drives
  logic [31:0] imm_ext = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input outs_t e);
    check("imem_req",    32'(imem_req),    32'(e.req));
    check("imem_addr",   imem_addr,        e.addr);
    check("instr_valid", 32'(instr_valid), 32'(e.valid));
    check("pc_load",     32'(pc_load),     32'(e.load));
    check("pc_src",      32'(pc_src),      32'(e.src));
    check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
    check("instr",       instr,            e.instr);
    check("instr_pc",    instr_pc,         e.ipc);
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.req   = m_fetching;
    o.addr  = m_fetching ? pc : 32'h0;
    o.valid = m_holding;
    o.load  = m_holding && id_ready;
    o.src   = m_holding && id_ready && branch_taken;
    o.fault = m_faulted;
    o.instr = m_faulted ? 32'h0 : m_instr;
    o.ipc   = m_faulted ? 32'h0 : m_ipc;
    return o;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    if (m_faulted) begin
      // only reset leaves a fault
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_fetching = 1'b0;
        m_holding  = 1'b1;
        m_instr    = imem_rdata;
        m_ipc      = pc;
        m_waited   = 0;
      end else begin
        m_waited++;
        if (m_waited == MAX_WAIT) begin
          m_fetching = 1'b0;
          m_faulted  = 1'b1;
        end
      end
    end else if (m_holding) begin
      if (id_ready) begin
        m_holding  = 1'b0;
        m_fetching = !halt;
        m_pc       = branch_taken ? m_pc + imm_ext : m_pc + 32'd4;
      end
    end else if (!halt) begin
      m_fetching = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_fetching = 1'b0;
    m_holding  = 1'b0;
    m_faulted  = 1'b0;
    m_waited   = 0;
    m_instr    = '0;
    m_ipc      = '0;
    m_pc       = '0;
  endtask

  // One clock cycle: drive, let settle, compare, step model, cross the edge.
  task automatic cycle(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic hlt, input bit use_exp, input outs_t exp_o);
    imem_ack     = ack;
    imem_rdata   = rdata;
    id_ready     = rdy;
    branch_taken = br;
    halt         = hlt;
    pc           = m_pc;
    #2;
    if (use_exp) check_outs(exp_o);
    else         check_outs(model_outs());
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic ack, input logic [31:0] rdata, input logic rdy,
                     input logic br, input logic hlt);
    cycle(ack, rdata, rdy, br, hlt, 1'b0, '0);
  endtask

  function automatic outs_t mk(input logic req, input logic [31:0] addr, input logic valid,
                               input logic load, input logic src, input logic fault,
                               input logic [31:0] ins, input logic [31:0] ipc);
    outs_t o;
    o.req = req; o.addr = addr; o.valid = valid; o.load = load;
    o.src = src; o.fault = fault; o.instr = ins; o.ipc = ipc;
    return o;
  endfunction

  function automatic vec_t mkv(input logic ack, input logic [31:0] rdata, input logic rdy,
                               input logic br, input logic hlt, input outs_t e);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.hlt = hlt; v.e = e;
    return v;
  endfunction

  // Assert reset between edges, confirm outputs drop at once, release mid-cycle.
  task automatic apply_reset();
    #2;
    Async_reset = 1'b0;
    #1;
    check("rst imem_req",    32'(imem_req),    32'd0);
    check("rst imem_addr",   imem_addr,        32'd0);
    check("rst instr_valid", 32'(instr_valid), 32'd0);
    check("rst pc_load",     32'(pc_load),     32'd0);
    check("rst pc_src",      32'(pc_src),      32'd0);
    check("rst fetch_fault", 32'(fetch_fault), 32'd0);
    check("rst instr",       instr,            32'd0);
    check("rst instr_pc",    instr_pc,         32'd0);
    model_reset();
    pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Async_reset = 1'b1;
  endtask

  vec_t tbl[8];

  initial begin
    // First fetches after reset, pc starts at 0.
    tbl[0] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0));
    tbl[1] = mkv(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0));
    tbl[2] = mkv(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'd0));
    tbl[3] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'd0));
    tbl[4] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'd0));
    tbl[5] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'd0));
    tbl[6] = mkv(1'b1, 32'h00a00113, 1'b0, 1'b0, 1'b0, mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'd0));
    tbl[7] = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00a00113, 32'd4));

    model_reset();
    apply_reset();

    // Basic fetch, then an ack delayed by 3 cycles; branch ignored while not accepting.
    for (int i = 0; i < 8; i++)
      cycle(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].br, tbl[i].hlt, 1'b1, tbl[i].e);

    // Walk the PC to 16, stall decode 5 cycles, then take a branch of -8.
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);          // accept -> pc 8
    run(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);          // accept -> pc 12
    run(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0);
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);          // accept -> pc 16
    run(1'b1, 32'hfe000ce3, 1'b0, 1'b0, 1'b0);
    imm_ext = 32'hffff_fff8;
    for (int i = 0; i < 5; i++) run(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1,
          mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hfe000ce3, 32'd16));
    cycle(1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'hfe000ce3, 32'd16));
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);          // accept -> pc 12

    // Timeout: 15 unanswered REQ cycles, then fault; a late ack is ignored.
    for (int i = 0; i < MAX_WAIT; i++) run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h44444444, 1'b1, 1'b1, 1'b0, 1'b1,
            mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0));
    apply_reset();

    // Ack on the last allowed cycle wins over the timeout.
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);          // IDLE -> REQ
    for (int i = 0; i < MAX_WAIT - 1; i++) run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55555555, 32'd0));

    // halt during REQ: request completes, accept goes to IDLE, then resume.
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);          // accept -> pc 4
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 32'h66666666, 1'b0, 1'b0, 1'b1);
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);          // accept -> pc 8, IDLE
    for (int i = 0; i < 4; i++) run(1'(i % 2), 32'h77777777, 1'b1, 1'b1, 1'b1);
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);          // IDLE -> REQ
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66666666, 32'd4));

    // Async reset in the middle of a REQ cycle.
    check("pre-reset imem_req", 32'(imem_req), 32'd1);
    apply_reset();

    // Async reset while decode is accepting in HOLD.
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    id_ready = 1'b1;
    #1;
    check("pre-reset pc_load", 32'(pc_load), 32'd1);
    apply_reset();

    // Randomized traffic; some blocks starve acks to provoke timeouts.
    for (int blk = 0; blk < 12; blk++) begin
      for (int i = 0; i < 50; i++) begin
        logic a;
        imm_ext = ($urandom & 32'h0000_03fc) - 32'h0000_0200;
        a = (blk % 4 == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 99) == 0) apply_reset();
        else run(a, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      end
      if (m_faulted) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
